// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake, synchronous flush and a 2-entry skid buffer.
// Optional stall counter output enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  CLEAR_VAL = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BUSY  = 2'b01,
        S_FULL  = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             out_valid_nxt;
    logic             in_ready_nxt;
    logic [1:0]       occupancy_nxt;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    // State, storage and handshake outputs all come straight from flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_EMPTY;
            main_q    <= CLEAR_VAL;
            skid_q    <= CLEAR_VAL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else begin
            state     <= state_nxt;
            main_q    <= main_nxt;
            skid_q    <= skid_nxt;
            out_valid <= out_valid_nxt;
            in_ready  <= in_ready_nxt;
            occupancy <= occupancy_nxt;
        end
    end

    // Next state and storage; flush overrides any handshake in the same cycle
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = S_EMPTY;
            main_nxt  = CLEAR_VAL;
            skid_nxt  = CLEAR_VAL;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = S_BUSY;
                        main_nxt  = in_data;
                    end
                end
                S_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (in_fire) begin
                        state_nxt = S_FULL;
                        skid_nxt  = in_data;
                    end else if (out_fire) begin
                        state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_nxt = S_BUSY;
                        main_nxt  = skid_q;
                    end
                end
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    // Output flags decoded from the next state so they are registered with it
    always_comb begin
        out_valid_nxt = 1'b0;
        in_ready_nxt  = 1'b1;
        occupancy_nxt = 2'd0;
        case (state_nxt)
            S_BUSY: begin
                out_valid_nxt = 1'b1;
                occupancy_nxt = 2'd1;
            end
            S_FULL: begin
                out_valid_nxt = 1'b1;
                in_ready_nxt  = 1'b0;
                occupancy_nxt = 2'd2;
            end
            default: ;
        endcase
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating backpressure counter; only reset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: vector table, hand-written corner sequences and
// a randomized run against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int unsigned W   = 8;
    localparam logic [W-1:0] CLR = 8'h5A;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]  stall_cnt;
    logic [2:0]   stall_cnt3;
    logic         in_ready3;
    logic         out_valid3;
    logic [W-1:0] out_data3;
    logic [1:0]   occupancy3;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(W), .CLEAR_VAL(CLR), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_skid #(.WIDTH(W), .CLEAR_VAL(CLR), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .occupancy(occupancy3), .stall_cnt(stall_cnt3)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         fl;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         ov;
        logic         ir;
        logic [1:0]   occ;
        logic [W-1:0] od;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [W-1:0] id,
                                input logic ordy, input logic ov, input logic ir,
                                input logic [1:0] occ, input logic [W-1:0] od);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.occ = occ; v.od = od;
        return v;
    endfunction

    // Reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] idle_data;
    int unsigned  m_cnt;
    int unsigned  m_cnt3;

    initial begin
        // streaming
        tbl[0]  = mk(0, 1, 8'h01, 1,  1, 1, 1, 8'h01);
        tbl[1]  = mk(0, 1, 8'h02, 1,  1, 1, 1, 8'h02);
        tbl[2]  = mk(0, 1, 8'h03, 1,  1, 1, 1, 8'h03);
        tbl[3]  = mk(0, 0, 8'h00, 1,  0, 1, 0, 8'h03);
        // backpressure, then drain in order
        tbl[4]  = mk(0, 1, 8'h0A, 0,  1, 1, 1, 8'h0A);
        tbl[5]  = mk(0, 1, 8'h0B, 0,  1, 0, 2, 8'h0A);
        tbl[6]  = mk(0, 1, 8'h0C, 0,  1, 0, 2, 8'h0A);
        tbl[7]  = mk(0, 1, 8'h0C, 1,  1, 1, 1, 8'h0B);
        tbl[8]  = mk(0, 1, 8'h0C, 1,  1, 1, 1, 8'h0C);
        tbl[9]  = mk(0, 0, 8'h00, 1,  0, 1, 0, 8'h0C);
        // simultaneous in/out fire in BUSY
        tbl[10] = mk(0, 1, 8'h04, 0,  1, 1, 1, 8'h04);
        tbl[11] = mk(0, 1, 8'h05, 1,  1, 1, 1, 8'h05);
        tbl[12] = mk(0, 0, 8'h00, 0,  1, 1, 1, 8'h05);
        // flush from FULL with both handshakes active
        tbl[13] = mk(0, 1, 8'h06, 0,  1, 0, 2, 8'h05);
        tbl[14] = mk(1, 1, 8'h0D, 1,  0, 1, 0, CLR);
        tbl[15] = mk(0, 0, 8'h00, 1,  0, 1, 0, CLR);
        // flush in BUSY discards accepted data; flush in EMPTY
        tbl[16] = mk(0, 1, 8'h07, 0,  1, 1, 1, 8'h07);
        tbl[17] = mk(1, 1, 8'h08, 0,  0, 1, 0, CLR);
        tbl[18] = mk(1, 0, 8'h00, 0,  0, 1, 0, CLR);
        tbl[19] = mk(0, 1, 8'h09, 1,  1, 1, 1, 8'h09);
        tbl[20] = mk(0, 0, 8'h00, 1,  0, 1, 0, 8'h09);

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_od", 32'(out_data), 32'(CLR));
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            flush = tbl[i].fl; in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
            tick();
            chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d_ir", i), 32'(in_ready), 32'(tbl[i].ir));
            chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(tbl[i].occ));
            chk($sformatf("vec%0d_od", i), 32'(out_data), 32'(tbl[i].od));
        end
        flush = 1'b0;

        // asynchronous reset while FULL
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_occ", 32'(occupancy), 32'd2);
        chk("pre_rst_od", 32'(out_data), 32'h11);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_ov", 32'(out_valid), 32'd0);
        chk("async_rst_od", 32'(out_data), 32'(CLR));
        chk("async_rst_ir", 32'(in_ready), 32'd1);
        chk("async_rst_occ", 32'(occupancy), 32'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        chk("post_rst_od", 32'(out_data), 32'h33);
        chk("post_rst_occ", 32'(occupancy), 32'd1);
        tick();
        chk("post_rst_drain", 32'(occupancy), 32'd0);

`ifdef PIPE_STAGE_PERF_EN
        reset = 1'b1; #1; reset = 1'b0;
        chk("perf_rst", 32'(stall_cnt), 32'd0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("perf_stall5", 32'(stall_cnt), 32'd5);
        chk("perf3_stall5", 32'(stall_cnt3), 32'd5);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf_flush_keep", 32'(stall_cnt), 32'd5);
        chk("perf_flush_occ", 32'(occupancy3), 32'd0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("perf3_sat", 32'(stall_cnt3), 32'd7);
        chk("perf_15", 32'(stall_cnt), 32'd15);
        tick();
        chk("perf3_sat_hold", 32'(stall_cnt3), 32'd7);
`endif

        // randomized run against the queue model
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        reset = 1'b0;
        q.delete();
        idle_data = CLR;
        m_cnt = 0;
        m_cnt3 = 0;
        for (int c = 0; c < 2000; c++) begin
            logic         e_ov, e_ir, fire_in, fire_out;
            logic [W-1:0] e_od;
            e_ov = (q.size() > 0);
            e_ir = (q.size() < 2);
            e_od = e_ov ? q[0] : idle_data;
            chk($sformatf("rnd%0d_ov", c), 32'(out_valid), 32'(e_ov));
            chk($sformatf("rnd%0d_ir", c), 32'(in_ready), 32'(e_ir));
            chk($sformatf("rnd%0d_occ", c), 32'(occupancy), 32'(q.size()));
            chk($sformatf("rnd%0d_od", c), 32'(out_data), 32'(e_od));
`ifdef PIPE_STAGE_PERF_EN
            chk($sformatf("rnd%0d_cnt", c), 32'(stall_cnt), m_cnt);
            chk($sformatf("rnd%0d_cnt3", c), 32'(stall_cnt3), m_cnt3);
`endif
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);

            fire_in  = in_valid && e_ir;
            fire_out = e_ov && out_ready;
            if (e_ov && !out_ready) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt3 < 7) m_cnt3++;
            end
            if (flush) begin
                q.delete();
                idle_data = CLR;
            end else begin
                if (fire_out) idle_data = q.pop_front();
                if (fire_in) q.push_back(in_data);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
